// File: rtl/contador_updown_modo.sv
// contador_updown_modo: servo position index generator.
// Produces a position in 0..M-1 in one of four modes (ping-pong, wrap-up,
// wrap-down, hold). Ping-pong can dwell PAUSA extra enabled cycles at each
// extreme. Also provides a synchronous preload and a one-cycle turnaround
// pulse (virou). Position flags fim/inicio/meio are decoded from value.
module contador_updown_modo #(
  parameter int M     = 14,
  parameter int N     = 4,
  parameter int PAUSA = 0
) (
  input  logic         clock,
  input  logic         zera_as_n,
  input  logic         zera_s,
  input  logic         conta,
  input  logic         carrega,
  input  logic [N-1:0] valor_carga,
  input  logic [1:0]   modo,
  output logic [N-1:0] value,
  output logic         direcao,
  output logic         fim,
  output logic         inicio,
  output logic         meio,
  output logic         virou
);

  // Parameter sanity: reject configurations that cannot represent M-1
  // or whose dwell does not fit the 8-bit dwell counter.
  generate
    if (M < 1) begin : g_bad_m
      $error("contador_updown_modo: M must be >= 1");
    end
    if (N < $clog2(M)) begin : g_bad_n
      $error("contador_updown_modo: N too small for M");
    end
    if (PAUSA < 0 || PAUSA > 255) begin : g_bad_pausa
      $error("contador_updown_modo: PAUSA must be in 0..255");
    end
  endgenerate

  localparam logic [N-1:0] VMAX     = N'(M - 1);
  localparam logic [N-1:0] VMID     = N'((M - 1) / 2);
  // Landing points after a ping-pong reversal. With M==1 both collapse to 0
  // so the value never leaves the single legal position.
  localparam logic [N-1:0] VTURN_DN = N'((M >= 2) ? (M - 2) : 0);
  localparam logic [N-1:0] VTURN_UP = N'((M >= 2) ? 1 : 0);
  localparam logic [7:0]   PAUSA_C  = 8'(PAUSA);

  logic [N-1:0] value_q, value_d;
  logic         dir_q, dir_d;
  logic [7:0]   dwell_q, dwell_d;
  logic         virou_q, virou_d;

  // Next-state: priority zera_s > carrega > conta, then mode-specific step.
  always_comb begin
    value_d = value_q;
    dir_d   = dir_q;
    dwell_d = dwell_q;
    virou_d = 1'b0;
    if (zera_s) begin
      value_d = '0;
      dir_d   = 1'b1;
      dwell_d = '0;
    end else if (carrega) begin
      value_d = (valor_carga > VMAX) ? VMAX : valor_carga;
      dwell_d = '0;
    end else if (conta) begin
      case (modo)
        2'b00: begin
          if (dir_q) begin
            if (value_q < VMAX) begin
              value_d = value_q + N'(1);
            end else if (dwell_q < PAUSA_C) begin
              dwell_d = dwell_q + 8'd1;
            end else begin
              dir_d   = 1'b0;
              value_d = VTURN_DN;
              dwell_d = '0;
              virou_d = 1'b1;
            end
          end else begin
            if (value_q != '0) begin
              value_d = value_q - N'(1);
            end else if (dwell_q < PAUSA_C) begin
              dwell_d = dwell_q + 8'd1;
            end else begin
              dir_d   = 1'b1;
              value_d = VTURN_UP;
              dwell_d = '0;
              virou_d = 1'b1;
            end
          end
        end
        2'b01: begin
          dir_d   = 1'b1;
          dwell_d = '0;
          if (value_q < VMAX) begin
            value_d = value_q + N'(1);
          end else begin
            value_d = '0;
            virou_d = 1'b1;
          end
        end
        2'b10: begin
          dir_d   = 1'b0;
          dwell_d = '0;
          if (value_q != '0) begin
            value_d = value_q - N'(1);
          end else begin
            value_d = VMAX;
            virou_d = 1'b1;
          end
        end
        default: begin
          // Hold: everything frozen, dwell preserved.
        end
      endcase
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      value_q <= '0;
      dir_q   <= 1'b1;
      dwell_q <= '0;
      virou_q <= 1'b0;
    end else begin
      value_q <= value_d;
      dir_q   <= dir_d;
      dwell_q <= dwell_d;
      virou_q <= virou_d;
    end
  end

  assign value   = value_q;
  assign direcao = dir_q;
  assign virou   = virou_q;
  assign fim     = (value_q == VMAX);
  assign inicio  = (value_q == '0);
  assign meio    = (value_q == VMID);

endmodule

// File: tb/tb_contador_updown_modo.sv
// Bench for contador_updown_modo: two instances (PAUSA=0 and PAUSA=2) share
// the same stimulus; both are checked against a behavioural model, plus
// closed-form sweep expectations and a hand-computed vector table.
module tb_contador_updown_modo;

  localparam int M   = 14;
  localparam int N   = 4;
  localparam int TOP = M - 1;
  localparam int MID = (M - 1) / 2;

  logic         clock;
  logic         zera_as_n;
  logic         zera_s;
  logic         conta;
  logic         carrega;
  logic [N-1:0] valor_carga;
  logic [1:0]   modo;

  logic [N-1:0] value0, value2;
  logic         dir0, fim0, ini0, meio0, vir0;
  logic         dir2, fim2, ini2, meio2, vir2;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state, index 0 -> PAUSA=0 instance, 1 -> PAUSA=2.
  int pausa [2] = '{0, 2};
  int mval  [2];
  int mdir  [2];
  int mdw   [2];
  int mvir  [2];

  typedef struct {
    bit       zs;
    bit       ld;
    bit       cnt;
    bit [1:0] md;
    int       lv;
    int       ev;
    int       ed;
    int       evir;
  } vec_t;

  vec_t tbl[$];

  contador_updown_modo #(.M(M), .N(N), .PAUSA(0)) dut0 (
    .clock(clock), .zera_as_n(zera_as_n), .zera_s(zera_s), .conta(conta),
    .carrega(carrega), .valor_carga(valor_carga), .modo(modo),
    .value(value0), .direcao(dir0), .fim(fim0), .inicio(ini0),
    .meio(meio0), .virou(vir0)
  );

  contador_updown_modo #(.M(M), .N(N), .PAUSA(2)) dut2 (
    .clock(clock), .zera_as_n(zera_as_n), .zera_s(zera_s), .conta(conta),
    .carrega(carrega), .valor_carga(valor_carga), .modo(modo),
    .value(value2), .direcao(dir2), .fim(fim2), .inicio(ini2),
    .meio(meio2), .virou(vir2)
  );

  // Clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mval[k] = 0; mdir[k] = 1; mdw[k] = 0; mvir[k] = 0;
    end
  endtask

  // Behavioural rules: one enabled step of the position generator.
  task automatic model_edge(input bit zs, input bit ld, input bit cnt,
                            input bit [1:0] md, input int lv);
    for (int k = 0; k < 2; k++) begin
      mvir[k] = 0;
      if (zs) begin
        mval[k] = 0; mdir[k] = 1; mdw[k] = 0;
      end else if (ld) begin
        mval[k] = (lv > TOP) ? TOP : lv;
        mdw[k]  = 0;
      end else if (cnt) begin
        if (md == 2'b00) begin
          if (mdir[k] == 1 && mval[k] < TOP) mval[k]++;
          else if (mdir[k] == 0 && mval[k] > 0) mval[k]--;
          else if (mdw[k] < pausa[k]) mdw[k]++;
          else begin
            mval[k] = (mdir[k] == 1) ? TOP - 1 : 1;
            mdir[k] = 1 - mdir[k];
            mdw[k]  = 0;
            mvir[k] = 1;
          end
        end else if (md == 2'b01) begin
          mdir[k] = 1; mdw[k] = 0;
          mval[k] = (mval[k] + 1) % M;
          mvir[k] = (mval[k] == 0) ? 1 : 0;
        end else if (md == 2'b10) begin
          mdir[k] = 0; mdw[k] = 0;
          mval[k] = (mval[k] + M - 1) % M;
          mvir[k] = (mval[k] == TOP) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic check_dut(input int k, input string tag);
    int v, d, f, i, m, r;
    if (k == 0) begin
      v = int'(value0); d = int'(dir0); f = int'(fim0);
      i = int'(ini0); m = int'(meio0); r = int'(vir0);
    end else begin
      v = int'(value2); d = int'(dir2); f = int'(fim2);
      i = int'(ini2); m = int'(meio2); r = int'(vir2);
    end
    cmp($sformatf("%s[p%0d].value", tag, pausa[k]), v, mval[k]);
    cmp($sformatf("%s[p%0d].direcao", tag, pausa[k]), d, mdir[k]);
    cmp($sformatf("%s[p%0d].virou", tag, pausa[k]), r, mvir[k]);
    cmp($sformatf("%s[p%0d].fim", tag, pausa[k]), f, (mval[k] == TOP) ? 1 : 0);
    cmp($sformatf("%s[p%0d].inicio", tag, pausa[k]), i, (mval[k] == 0) ? 1 : 0);
    cmp($sformatf("%s[p%0d].meio", tag, pausa[k]), m, (mval[k] == MID) ? 1 : 0);
  endtask

  task automatic check_both(input string tag);
    check_dut(0, tag);
    check_dut(1, tag);
  endtask

  // Drive one set of inputs, let one edge pass, advance the model.
  task automatic step(input bit zs, input bit ld, input bit cnt,
                      input bit [1:0] md, input int lv);
    zera_s      = zs;
    carrega     = ld;
    conta       = cnt;
    modo        = md;
    valor_carga = N'(lv);
    @(posedge clock);
    #1;
    model_edge(zs, ld, cnt, md, lv);
  endtask

  task automatic add_vec(input bit zs, input bit ld, input bit cnt,
                         input bit [1:0] md, input int lv,
                         input int ev, input int ed, input int evir);
    vec_t t;
    t.zs = zs; t.ld = ld; t.cnt = cnt; t.md = md; t.lv = lv;
    t.ev = ev; t.ed = ed; t.evir = evir;
    tbl.push_back(t);
  endtask

  // Async reset pulse placed mid-cycle; checks the immediate clear.
  task automatic async_reset_pulse(input string tag);
    #3;
    zera_as_n = 1'b0;
    #1;
    model_reset();
    check_both(tag);
    #2;
    zera_as_n = 1'b1;
  endtask

  initial begin
    int p, ev, evir;
    int r;
    bit zs, ld, cnt;
    bit [1:0] md;

    zera_as_n   = 1'b0;
    zera_s      = 1'b0;
    conta       = 1'b0;
    carrega     = 1'b0;
    valor_carga = '0;
    modo        = 2'b00;
    model_reset();

    // Reset state
    #12;
    check_both("reset");
    zera_as_n = 1'b1;

    // Count to 5, then async clear mid-cycle, then first step gives 1
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 2'b00, 0);
      check_both("count5");
    end
    cmp("count5.value", int'(value0), 5);
    async_reset_pulse("async_clear");
    step(0, 0, 1, 2'b00, 0);
    check_both("after_async");
    cmp("after_async.value", int'(value0), 1);

    // Ping-pong sweeps from reset, closed-form expectations
    async_reset_pulse("sweep_reset");
    for (int i = 1; i <= 32; i++) begin
      step(0, 0, 1, 2'b00, 0);
      check_both("sweep");
      p    = i % 26;
      ev   = (p <= TOP) ? p : 26 - p;
      evir = (p == 14 || (p == 1 && i > 1)) ? 1 : 0;
      cmp($sformatf("sweep_p0.value@%0d", i), int'(value0), ev);
      cmp($sformatf("sweep_p0.virou@%0d", i), int'(vir0), evir);
      p = i % 30;
      if (p == 0) ev = 0;
      else if (p <= 13) ev = p;
      else if (p <= 15) ev = 13;
      else if (p <= 28) ev = 28 - p;
      else ev = 0;
      evir = (p == 16 || (p == 1 && i > 1)) ? 1 : 0;
      cmp($sformatf("sweep_p2.value@%0d", i), int'(value2), ev);
      cmp($sformatf("sweep_p2.virou@%0d", i), int'(vir2), evir);
    end

    // Hand-computed vectors for the PAUSA=0 instance
    add_vec(1, 0, 0, 2'b00, 0,  0,  1, 0);  // sync clear
    add_vec(0, 1, 0, 2'b00, 12, 12, 1, 0);  // load 12
    add_vec(0, 0, 1, 2'b01, 0,  13, 1, 0);  // wrap-up
    add_vec(0, 0, 1, 2'b01, 0,  0,  1, 1);  // wrap-up wraps
    add_vec(0, 0, 1, 2'b01, 0,  1,  1, 0);
    add_vec(0, 1, 0, 2'b10, 1,  1,  1, 0);  // load keeps direcao
    add_vec(0, 0, 1, 2'b10, 0,  0,  0, 0);  // wrap-down
    add_vec(0, 0, 1, 2'b10, 0,  13, 0, 1);  // wrap-down wraps
    add_vec(0, 0, 1, 2'b10, 0,  12, 0, 0);
    add_vec(0, 1, 0, 2'b10, 15, 13, 0, 0);  // saturating load
    add_vec(1, 1, 0, 2'b00, 5,  0,  1, 0);  // clear beats load
    add_vec(0, 1, 1, 2'b00, 7,  7,  1, 0);  // load beats step
    for (int i = 0; i < 5; i++)
      add_vec(0, 0, 1, 2'b11, 0, 7, 1, 0);  // hold ignores conta
    add_vec(0, 0, 0, 2'b00, 0,  7,  1, 0);  // gap
    add_vec(0, 0, 1, 2'b00, 0,  8,  1, 0);
    add_vec(0, 0, 0, 2'b00, 0,  8,  1, 0);
    add_vec(0, 0, 1, 2'b00, 0,  9,  1, 0);
    add_vec(0, 1, 0, 2'b00, 13, 13, 1, 0);
    add_vec(0, 0, 1, 2'b10, 0,  12, 0, 0);
    add_vec(0, 0, 1, 2'b00, 0,  11, 0, 0);  // ping-pong keeps down direction
    add_vec(0, 1, 0, 2'b00, 1,  1,  0, 0);
    add_vec(0, 0, 1, 2'b00, 0,  0,  0, 0);
    add_vec(0, 0, 1, 2'b00, 0,  1,  1, 1);  // reversal at 0
    add_vec(0, 0, 0, 2'b00, 0,  1,  1, 0);  // virou drops with conta=0

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].zs, tbl[i].ld, tbl[i].cnt, tbl[i].md, tbl[i].lv);
      cmp($sformatf("tbl%0d.value", i), int'(value0), tbl[i].ev);
      cmp($sformatf("tbl%0d.direcao", i), int'(dir0), tbl[i].ed);
      cmp($sformatf("tbl%0d.virou", i), int'(vir0), tbl[i].evir);
      check_both($sformatf("tbl%0d", i));
    end

    // Randomised stimulus against the model
    for (int i = 0; i < 600; i++) begin
      zs  = ($urandom_range(24, 0) == 0);
      ld  = ($urandom_range(11, 0) == 0);
      cnt = ($urandom_range(3, 0) != 0);
      r   = $urandom_range(8, 0);
      md  = (r <= 5) ? 2'b00 : 2'(r - 5);
      step(zs, ld, cnt, md, $urandom_range(15, 0));
      check_both($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
